// File: rtl/cpu_pkg.sv
// Shared definitions for the LoongArch pipeline: branch opcodes, reset PC
// and the IF->ID register layout.
package cpu_pkg;

   localparam logic [5:0]  OP_B   = 6'h14;
   localparam logic [5:0]  OP_BL  = 6'h15;
   localparam logic [5:0]  OP_BEQ = 6'h16;
   localparam logic [5:0]  OP_BNE = 6'h17;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

   localparam int IF_TO_ID_W = 65;

   // IF->ID register; an all-zero value is the bubble encoding.
   typedef struct packed {
      logic        predict;
      logic [31:0] inst;
      logic [31:0] pc;
   } if_to_id_t;

endpackage

// File: rtl/if_predecode.sv
// Static branch predictor: b/bl always taken, beq/bne taken when the
// offset is negative (backward), everything else not taken.
module if_predecode
   import cpu_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output logic        predict,
   output logic [31:0] target
);

   logic [31:0] offs;

   // Decode opcode and sign-extend the matching branch offset.
   always_comb begin
      predict = 1'b0;
      offs    = '0;
      case (inst[31:26])
         OP_B, OP_BL: begin
            predict = 1'b1;
            offs    = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
         end
         OP_BEQ, OP_BNE: begin
            predict = inst[25];
            offs    = {{14{inst[25]}}, inst[25:10], 2'b00};
         end
         default: begin
            predict = 1'b0;
            offs    = '0;
         end
      endcase
   end

   assign target = pc + offs;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// SRAM, buffers returned data across decode stalls and holds the IF->ID
// register {predict, inst, pc}.
// Optional static prediction is enabled by defining IF_STATIC_PREDICT_EN;
// without it predict is 0 and fetch is purely sequential.
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ID_allowin,
   input  logic                  flush,
   input  logic [31:0]           pc_real,
   output logic                  inst_sram_en,
   output logic [31:0]           inst_sram_addr,
   input  logic [31:0]           inst_sram_rdata,
   output logic [IF_TO_ID_W-1:0] IF_to_ID_zip
);

   logic        fs_valid_q, fs_valid_d;
   logic [31:0] fs_pc_q, fs_pc_d;
   logic [31:0] ibuf_q, ibuf_d;
   logic        ibuf_valid_q, ibuf_valid_d;
   if_to_id_t   zip_q, zip_d;

   logic [31:0] fs_inst;
   logic [31:0] pc_plus4;
   logic [31:0] seq_pc;
   logic        predict;

   // Instruction for fs_pc: buffered copy wins over the live SRAM output.
   assign fs_inst  = ibuf_valid_q ? ibuf_q : inst_sram_rdata;
   assign pc_plus4 = fs_pc_q + 32'd4;

`ifdef IF_STATIC_PREDICT_EN
   logic [31:0] target;

   if_predecode u_predecode (
      .inst    (fs_inst),
      .pc      (fs_pc_q),
      .predict (predict),
      .target  (target)
   );

   assign seq_pc = predict ? target : pc_plus4;
`else
   assign predict = 1'b0;
   assign seq_pc  = pc_plus4;
`endif

   // Next-state and SRAM request: redirect, then cold start, then advance or stall.
   always_comb begin
      fs_valid_d     = fs_valid_q;
      fs_pc_d        = fs_pc_q;
      ibuf_d         = ibuf_q;
      ibuf_valid_d   = ibuf_valid_q;
      zip_d          = zip_q;
      inst_sram_en   = 1'b0;
      inst_sram_addr = '0;
      if (rst) begin
         inst_sram_en   = 1'b0;
         inst_sram_addr = '0;
      end else if (flush) begin
         inst_sram_en   = 1'b1;
         inst_sram_addr = pc_real;
         fs_pc_d        = pc_real;
         fs_valid_d     = 1'b1;
         ibuf_valid_d   = 1'b0;
         if (ID_allowin) zip_d = '0;
      end else if (!fs_valid_q) begin
         inst_sram_en   = 1'b1;
         inst_sram_addr = RESET_PC;
         fs_pc_d        = RESET_PC;
         fs_valid_d     = 1'b1;
         if (ID_allowin) zip_d = '0;
      end else if (ID_allowin) begin
         zip_d.predict  = predict;
         zip_d.inst     = fs_inst;
         zip_d.pc       = fs_pc_q;
         inst_sram_en   = 1'b1;
         inst_sram_addr = seq_pc;
         fs_pc_d        = seq_pc;
         ibuf_valid_d   = 1'b0;
      end else if (!ibuf_valid_q) begin
         // First stall cycle: SRAM data is only valid now, so keep it.
         ibuf_d       = inst_sram_rdata;
         ibuf_valid_d = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fs_valid_q   <= 1'b0;
         fs_pc_q      <= '0;
         ibuf_q       <= '0;
         ibuf_valid_q <= 1'b0;
         zip_q        <= '0;
      end else begin
         fs_valid_q   <= fs_valid_d;
         fs_pc_q      <= fs_pc_d;
         ibuf_q       <= ibuf_d;
         ibuf_valid_q <= ibuf_valid_d;
         zip_q        <= zip_d;
      end
   end

   assign IF_to_ID_zip = zip_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a scoreboard queue: the driver pushes
// one expected record per cycle, the monitor pops and compares at negedge.
module tb_if_stage;

   localparam logic [31:0] B = 32'h1c00_0000;

`ifdef IF_STATIC_PREDICT_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   // b -8, bne +0x20, beq -0x10
   localparam logic [31:0] I_B   = 32'h53FF_FBFF;
   localparam logic [31:0] I_BNE = 32'h5C00_2000;
   localparam logic [31:0] I_BEQ = 32'h5BFF_F000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ID_allowin = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] pc_real = '0;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata = '0;
   logic [64:0] IF_to_ID_zip;

   typedef struct {
      bit          chk_zip;
      bit          exp_en;
      logic [31:0] exp_addr;
      logic [64:0] exp_zip;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   if_stage dut (
      .clk             (clk),
      .rst             (rst),
      .ID_allowin      (ID_allowin),
      .flush           (flush),
      .pc_real         (pc_real),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .IF_to_ID_zip    (IF_to_ID_zip)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         B + 32'h10: return I_B;
         B + 32'h20: return I_BNE;
         B + 32'h44: return I_BEQ;
         default:    return {6'h00, 4'hA, a[23:2]};
      endcase
   endfunction

   function automatic logic [64:0] z(input bit p, input logic [31:0] a);
      return {p, mem_word(a), a};
   endfunction

   // Synchronous SRAM; poison output when not enabled.
   always @(posedge clk)
      inst_sram_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : 32'hDEAD_BEEF;

   task automatic step(input bit r, input bit a, input bit f, input logic [31:0] pr,
                       input bit ee, input logic [31:0] ea, input bit cz,
                       input logic [64:0] ez);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ID_allowin = a; flush = f; pc_real = pr;
      e.chk_zip = cz; e.exp_en = ee; e.exp_addr = ea; e.exp_zip = ez;
      exp_q.push_back(e);
   endtask

   // Monitor: one transaction line per cycle, compare against scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         cyc++;
         $display("cyc %0d: en=%0b addr=%08h zip=%017h", cyc, inst_sram_en,
                  inst_sram_addr, IF_to_ID_zip);
         checks++;
         if (inst_sram_en !== e.exp_en) begin
            errors++;
            $display("FAIL en cyc %0d: got %0b want %0b", cyc, inst_sram_en, e.exp_en);
         end
         checks++;
         if (inst_sram_addr !== e.exp_addr) begin
            errors++;
            $display("FAIL addr cyc %0d: got %08h want %08h", cyc, inst_sram_addr, e.exp_addr);
         end
         if (e.chk_zip) begin
            checks++;
            if (IF_to_ID_zip !== e.exp_zip) begin
               errors++;
               $display("FAIL zip cyc %0d: got %017h want %017h", cyc, IF_to_ID_zip, e.exp_zip);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset, then straight-line fetch into the b -8 at 0x10.
      step(1, 1, 0, '0, 0, '0, 1, '0);
      step(1, 1, 0, '0, 0, '0, 1, '0);
      step(0, 1, 0, '0, 1, B,          1, '0);
      step(0, 1, 0, '0, 1, B + 32'h04, 1, '0);
      step(0, 1, 0, '0, 1, B + 32'h08, 1, z(0, B));
      step(0, 1, 0, '0, 1, B + 32'h0c, 1, z(0, B + 32'h04));
      step(0, 1, 0, '0, 1, B + 32'h10, 1, z(0, B + 32'h08));
      step(0, 1, 0, '0, 1, PE ? B + 32'h08 : B + 32'h14, 1, z(0, B + 32'h0c));
      step(0, 1, 0, '0, 1, PE ? B + 32'h0c : B + 32'h18, 1, z(PE, B + 32'h10));

      // Mid-stream reset: zip cleared on the first reset edge only.
      step(1, 1, 0, '0, 0, '0, 1, PE ? z(0, B + 32'h08) : z(0, B + 32'h14));
      step(1, 1, 0, '0, 0, '0, 1, '0);

      // Redirect to the forward bne, then decode redirect to 0x40.
      step(0, 1, 1, B + 32'h20, 1, B + 32'h20, 1, '0);
      step(0, 1, 0, '0,         1, B + 32'h24, 1, '0);
      step(0, 1, 1, B + 32'h40, 1, B + 32'h40, 1, z(0, B + 32'h20));
      step(0, 1, 0, '0,         1, B + 32'h44, 1, '0);
      step(0, 1, 0, '0, 1, PE ? B + 32'h34 : B + 32'h48, 1, z(0, B + 32'h40));
      step(0, 1, 0, '0, 1, PE ? B + 32'h38 : B + 32'h4c, 1, z(PE, B + 32'h44));

      // Three-cycle stall with a read outstanding.
      step(0, 0, 0, '0, 0, '0, 1, PE ? z(0, B + 32'h34) : z(0, B + 32'h48));
      step(0, 0, 0, '0, 0, '0, 1, PE ? z(0, B + 32'h34) : z(0, B + 32'h48));
      step(0, 0, 0, '0, 0, '0, 1, PE ? z(0, B + 32'h34) : z(0, B + 32'h48));
      step(0, 1, 0, '0, 1, PE ? B + 32'h3c : B + 32'h50, 1, PE ? z(0, B + 32'h34) : z(0, B + 32'h48));
      step(0, 1, 0, '0, 1, PE ? B + 32'h40 : B + 32'h54, 1, PE ? z(0, B + 32'h38) : z(0, B + 32'h4c));
      step(0, 1, 0, '0, 1, PE ? B + 32'h44 : B + 32'h58, 1, PE ? z(0, B + 32'h3c) : z(0, B + 32'h50));

      // Flush held across stall cycles, released with allowin.
      step(0, 0, 1, B + 32'h100, 1, B + 32'h100, 1, PE ? z(0, B + 32'h40) : z(0, B + 32'h54));
      step(0, 0, 1, B + 32'h100, 1, B + 32'h100, 1, PE ? z(0, B + 32'h40) : z(0, B + 32'h54));
      step(0, 1, 1, B + 32'h100, 1, B + 32'h100, 1, PE ? z(0, B + 32'h40) : z(0, B + 32'h54));
      step(0, 1, 0, '0,          1, B + 32'h104, 1, '0);
      step(0, 1, 0, '0,          1, B + 32'h108, 1, z(0, B + 32'h100));

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: %0d records left, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
